dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Responder (memory) end of the CPU data-memory port: accepts valid/good requests from the
//  CPU initiator, performs byte/half/word loads and stores against a word-organised array,
//  and returns sign- or zero-extended load data after a programmable latency.
//  Sits beside the instruction memory in the top level; it is a drop-in for the data-memory slot.
// PARAMETERS
//  DEPTH      1024  number of 32-bit words; power of two
//  LATENCY    1     cycles from request acceptance to good; legal range 1..15
//  INIT_FILE  ""    hex file loaded at elaboration ($readmemh); "" leaves contents X
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  valid      in   1   request present; initiator holds all request fields stable until good
//  addr       in   32  byte address; word index = addr[log2(DEPTH)+1:2], upper bits ignored (wrap)
//  memRead    in   1   load request
//  memWrite   in   1   store request
//  maskMode   in   2   0=byte, 1=half, 2=word, 3=reserved (treated as word)
//  sext       in   1   1=sign-extend, 0=zero-extend load data (byte/half only)
//  writeData  in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  good       out  1   one-cycle response strobe
//  readData   out  32  extended load data; valid while good=1, holds last value otherwise
//  readBack   out  32  raw aligned word read for the request (pre-write), same timing as readData
//  misaligned out  1   sticky; set when an accepted half access has addr[0]=1 or word has addr[1:0]!=0
// BEHAVIOUR
//  - Reset (sync): state=IDLE, good=0, readData=0, readBack=0, misaligned=0, counter=0.
//    Memory contents are not cleared. Reset mid-transaction aborts it; a pending store is dropped.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: valid=1 at cycle T accepts the request and latches all fields. LATENCY==1 goes directly to RESP
//    (good at T+1); otherwise load counter=LATENCY-1 and enter BUSY.
//    BUSY: decrement counter each cycle; at 1 go to RESP. good rises exactly at cycle T+LATENCY.
//    RESP: good=1 for exactly one cycle; readData/readBack driven; store committed at the end of this cycle.
//    Always returns to IDLE; valid still high in the following cycle counts as a NEW request.
//    Back-to-back throughput is therefore one request per LATENCY+1 cycles.
//  - Fields sampled only at acceptance; changes on inputs during BUSY/RESP are ignored.
//  - Alignment: half uses addr[1] to select the lane, word ignores addr[1:0]; addr[0] (half) and
//    addr[1:0] (word) are dropped and misaligned is set. misaligned clears only on reset.
//  - Load extract: byte lane=addr[1:0], half lane=addr[1]; sext replicates lane MSB, else zero-fill.
//    Word loads ignore sext.
//  - Store: byte/half writeData replicated into the selected lane; other lanes unchanged.
//  - memRead=memWrite=1: performs the store; readData/readBack return the pre-write value (read-before-write).
//  - memRead=memWrite=0: no-op; good still pulses; readData/readBack return the addressed data.
//  - Address wrap: index taken modulo DEPTH, no error.
// STRUCTURE
//  - Shared package: maskMode encodings (MM_BYTE/MM_HALF/MM_WORD), FSM state encodings,
//    and a shared load-extend function (also used by the CPU writeback stage).
//  - One sub-module: dmem_lane_ctrl (combinational: byte-enable generation, store-data replication,
//    load extract/extend). The array plus FSM remain in this module.
// TESTING
//  - Word store/load, LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 -> good one cycle after valid;
//    readData=0xDEADBEEF.
//  - Byte/half extend: word @0x20=0x80FF7F01. LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080;
//    LH @0x22 -> 0xFFFF80FF; LHU @0x20 -> 0x00007F01.
//  - Partial store: word=0x11223344; SB 0xAA @0x01 -> 0x1122AA44; SH 0xBEEF @0x02 -> 0xBEEFAA44.
//  - Latency: LATENCY=4; valid at cycle 10 -> good only at cycle 14; valid held through cycle 15
//    -> second good at cycle 19.
//  - Misaligned/wrap: LW @0x13 returns word @0x10, misaligned=1; DEPTH=1024, SW @0x1000 overwrites word 0.
//  - Reset mid-op: LATENCY=3, SW @0x40 accepted; reset asserted in cycle 2 -> no good pulse;
//    word @0x40 unchanged; outputs return to 0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared data-memory definitions: access-size encodings, responder FSM states,
// and the load extract/extend helper also used by the CPU writeback stage.
package dmem_responder_pkg;

    localparam logic [1:0] MM_BYTE = 2'd0;
    localparam logic [1:0] MM_HALF = 2'd1;
    localparam logic [1:0] MM_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Reserved size (3) falls into the word case.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lo,
                                                input logic [1:0] mode, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (mode)
            MM_BYTE: return {{24{sext & b[7]}}, b};
            MM_HALF: return {{16{sext & h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Combinational lane logic for one data-memory access: byte enables, store-data
// replication, load extract/extend and alignment detection.
module dmem_lane_ctrl
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  mode,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata,
    output logic        mis
);

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        mis       = (addr_lo != 2'b00);
        case (mode)
            MM_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                mis       = 1'b0;
            end
            MM_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                mis       = addr_lo[0];
            end
            default: ;
        endcase
    end

    assign rdata = load_extend(rword, addr_lo, mode, sext);

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array behind a valid/good handshake with a
// programmable response latency and read-before-write semantics.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 1,
    parameter     INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  maskMode,
    input  logic        sext,
    input  logic [31:0] writeData,
    output logic        good,
    output logic [31:0] readData,
    output logic [31:0] readBack,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    state_t        state;
    logic [3:0]    cnt;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    mode_q;
    logic          sext_q, wr_q;

    logic [AW+1:0] sel_addr;
    logic [31:0]   sel_wdata, rword, rdata, wdata_rep;
    logic [1:0]    sel_mode;
    logic          sel_sext, mis, accept, resp_next;
    logic [3:0]    be;

    // A read always happens, so memRead carries no extra meaning; upper address bits wrap.
    logic unused;
    assign unused = &{1'b0, memRead, addr[31:AW+2]};

    // In IDLE the live inputs feed the lane logic so LATENCY==1 can respond next cycle.
    assign sel_addr  = (state == ST_IDLE) ? addr[AW+1:0] : addr_q;
    assign sel_mode  = (state == ST_IDLE) ? maskMode     : mode_q;
    assign sel_sext  = (state == ST_IDLE) ? sext         : sext_q;
    assign sel_wdata = (state == ST_IDLE) ? writeData    : wdata_q;
    assign rword     = mem[sel_addr[AW+1:2]];

    assign accept    = (state == ST_IDLE) && valid;
    assign resp_next = (accept && LATENCY == 1) || (state == ST_BUSY && cnt == 4'd1);

    dmem_lane_ctrl u_lane (
        .addr_lo   (sel_addr[1:0]),
        .mode      (sel_mode),
        .sext      (sel_sext),
        .wdata     (sel_wdata),
        .rword     (rword),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata     (rdata),
        .mis       (mis)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            good       <= 1'b0;
            readData   <= 32'd0;
            readBack   <= 32'd0;
            misaligned <= 1'b0;
        end else begin
            good <= 1'b0;
            if (resp_next) begin
                good     <= 1'b1;
                readData <= rdata;
                readBack <= rword;
            end
            if (accept && mis) misaligned <= 1'b1;
            case (state)
                ST_IDLE: if (valid) begin
                    if (LATENCY == 1) state <= ST_RESP;
                    else begin
                        state <= ST_BUSY;
                        cnt   <= 4'(LATENCY - 1);
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= ST_RESP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request capture and the store commit at the end of the response cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr[AW+1:0];
            mode_q  <= maskMode;
            sext_q  <= sext;
            wr_q    <= memWrite;
            wdata_q <= writeData;
        end
        if (!reset && state == ST_RESP && wr_q) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
    end

endmodule
